capture_ctrl: RTL and testbench

Capture sequencer for the logic-analyzer sample buffer. It clears and fills the circular buffer, holds off triggers until every location has been written (buffer primed), and records a programmable number of post-trigger samples. It then streams the whole buffer out oldest-first over a valid/ready interface. It sits between the host/config logic and the buffer writer, driving that writer's write-enable and clear, and issuing read addresses to the buffer's read port.

---
 rtl/capture_ctrl.sv | 147 ++++++++++++++
 tb/tb_capture_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Capture sequencer for the logic-analyzer sample buffer: clears and fills the
// circular buffer, waits for the buffer to be primed, records post-trigger
// samples, then streams the whole buffer out oldest-first over valid/ready.
module capture_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int MEMORY_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trigger,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic                  primed,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  buf_clear,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_last,
    output logic [ADDR_WIDTH-1:0] trig_index,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        PRETRIG = 3'd2,
        ARMED   = 3'd3,
        POST    = 3'd4,
        READOUT = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEMORY_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tcnt_q, tcnt_d;
    logic [ADDR_WIDTH-1:0] beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0] trig_q, trig_d;

    // State and datapath registers; reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            tcnt_q  <= '0;
            beat_q  <= '0;
            raddr_q <= '0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tcnt_q  <= tcnt_d;
            beat_q  <= beat_d;
            raddr_q <= raddr_d;
            trig_q  <= trig_d;
        end
    end

    // Next-state and datapath update; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tcnt_d  = tcnt_q;
        beat_d  = beat_q;
        raddr_d = raddr_q;
        trig_d  = trig_q;
        if (abort) begin
            state_d = IDLE;
            pc_d    = '0;
            tcnt_d  = '0;
            beat_d  = '0;
            raddr_d = '0;
            trig_d  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        state_d = CLEAR;
                        pc_d    = '0;
                        tcnt_d  = '0;
                        beat_d  = '0;
                        raddr_d = '0;
                        trig_d  = '0;
                    end
                end
                CLEAR: state_d = PRETRIG;
                PRETRIG: begin
                    if (primed) state_d = ARMED;
                end
                ARMED: begin
                    if (trigger) begin
                        pc_d   = post_count;
                        tcnt_d = post_count;
                        if (post_count != '0) begin
                            state_d = POST;
                        end else begin
                            // waddr still addresses the sample written on this
                            // edge; the oldest sample sits one location past it.
                            state_d = READOUT;
                            raddr_d = waddr + ONE;
                            beat_d  = '0;
                            trig_d  = LAST_IDX - post_count;
                        end
                    end
                end
                POST: begin
                    tcnt_d = tcnt_q - ONE;
                    if (tcnt_q == ONE) begin
                        state_d = READOUT;
                        raddr_d = waddr + ONE;
                        beat_d  = '0;
                        trig_d  = LAST_IDX - pc_q;
                    end
                end
                READOUT: begin
                    if (o_ready) begin
                        raddr_d = raddr_q + ONE;
                        beat_d  = beat_q + ONE;
                        if (beat_q == LAST_IDX) state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign buf_clear    = (state_q == CLEAR);
    assign write_enable = (state_q == PRETRIG) || (state_q == ARMED) || (state_q == POST);
    assign o_valid      = (state_q == READOUT);
    assign o_last       = (state_q == READOUT) && (beat_q == LAST_IDX);
    assign o_data       = o_valid ? rdata : '0;
    assign raddr        = raddr_q;
    assign trig_index   = trig_q;
    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: a buffer-writer model feeds the DUT,
// and a capture model predicts every output from the recorded write history.
module tb_capture_ctrl;

    logic       clk, reset, arm, abort, trigger, primed, o_ready;
    logic [3:0] post_count, waddr, raddr, trig_index;
    logic [7:0] rdata, o_data, sample_in;
    logic       buf_clear, write_enable, o_valid, o_last, busy, done;

    capture_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MEMORY_SIZE(16)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
        .post_count(post_count), .primed(primed), .waddr(waddr), .rdata(rdata),
        .buf_clear(buf_clear), .write_enable(write_enable), .raddr(raddr),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
        .trig_index(trig_index), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Buffer writer: cleared by buf_clear, writes sample_in at wptr on each strobe.
    logic [7:0] mem [16];
    logic [3:0] wptr;
    int         wcount;
    assign waddr  = wptr;
    assign primed = (wcount >= 16);
    assign rdata  = mem[raddr];

    always @(posedge clk) begin
        if (reset || buf_clear) begin
            wptr   <= '0;
            wcount <= 0;
        end else if (write_enable) begin
            mem[wptr] <= sample_in;
            wptr      <= wptr + 4'd1;
            if (wcount < 16) wcount <= wcount + 1;
        end
    end

    always @(negedge clk) sample_in = 8'($urandom);

    int ready_mode = 0;
    int rpat = 0;
    always @(negedge clk) begin
        if (ready_mode == 1) o_ready = (rpat % 3 == 0);
        else                 o_ready = ($urandom_range(0, 3) != 0);
        rpat++;
    end

    // Capture model: phases of a capture, write history and predicted readout.
    typedef enum int {P_IDLE, P_CLEAR, P_FILL, P_WAIT, P_POST, P_READ, P_DONE} phase_t;
    phase_t     ph = P_IDLE;
    logic [7:0] hist[$];
    logic [7:0] stream [16];
    logic [7:0] tsample;
    int         beat, post_left, pc_m, start_addr, exp_trig;

    function automatic void start_readout();
        int nw = hist.size();
        for (int i = 0; i < 16; i++) stream[i] = hist[nw - 16 + i];
        start_addr = nw % 16;
        beat       = 0;
        exp_trig   = 15 - pc_m;
        ph         = P_READ;
    endfunction

    always @(posedge clk) begin
        if (reset || abort) begin
            ph = P_IDLE; beat = 0; exp_trig = 0;
        end else begin
            case (ph)
                P_IDLE, P_DONE: if (arm) begin ph = P_CLEAR; exp_trig = 0; hist.delete(); end
                P_CLEAR: ph = P_FILL;
                P_FILL: begin
                    hist.push_back(sample_in);
                    if (primed) ph = P_WAIT;
                end
                P_WAIT: begin
                    hist.push_back(sample_in);
                    if (trigger) begin
                        pc_m    = int'(post_count);
                        tsample = sample_in;
                        if (pc_m == 0) start_readout();
                        else begin post_left = pc_m; ph = P_POST; end
                    end
                end
                P_POST: begin
                    hist.push_back(sample_in);
                    post_left--;
                    if (post_left == 0) start_readout();
                end
                P_READ: if (o_ready) begin
                    beat++;
                    if (beat == 16) ph = P_DONE;
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of all DUT outputs against the model.
    bit check_en = 0;
    always @(negedge clk) begin
        if (check_en) begin
            chk("buf_clear", buf_clear, ph == P_CLEAR);
            chk("write_enable", write_enable, ph inside {P_FILL, P_WAIT, P_POST});
            chk("o_valid", o_valid, ph == P_READ);
            chk("o_last", o_last, (ph == P_READ) && (beat == 15));
            chk("busy", busy, !(ph inside {P_IDLE, P_DONE}));
            chk("done", done, ph == P_DONE);
            chk("trig_index", trig_index, exp_trig);
            if (ph == P_READ) begin
                chk("o_data", o_data, stream[beat]);
                chk("raddr", raddr, (start_addr + beat) % 16);
                if (beat == exp_trig) chk("trigger_sample", o_data, tsample);
            end
        end
    end

    // Observed activity per capture.
    int          clr_cnt, we_cnt, acc_cnt, last_cnt, dup_cnt;
    logic [15:0] mask;
    always @(posedge clk) begin
        if (buf_clear) clr_cnt++;
        if (write_enable) we_cnt++;
        if (o_valid && o_ready) begin
            acc_cnt++;
            if (mask[raddr]) dup_cnt++;
            mask[raddr] = 1'b1;
            if (o_last) last_cnt++;
        end
    end

    task automatic wait_phase(input phase_t p, input int budget, input string what);
        int n = 0;
        while (ph != p && n < budget) begin @(negedge clk); n++; end
        if (ph != p) begin
            n_checks++; n_fail++;
            $display("FAIL timeout_%s: got phase %0d expected %0d", what, ph, p);
        end
    endtask

    task automatic start_arm(input int pc, input bit held);
        @(negedge clk);
        arm = 1'b1; post_count = 4'(pc); trigger = held;
        clr_cnt = 0; we_cnt = 0; acc_cnt = 0; last_cnt = 0; dup_cnt = 0; mask = '0;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic run_capture(input int pc, input int delay, input bit held, input int rmode,
                               input int etrig, input int ewe);
        ready_mode = rmode;
        start_arm(pc, held);
        chk("clear_after_arm", buf_clear, 1);
        chk("done_after_arm", done, 0);
        repeat (4) @(negedge clk);
        arm = 1'b1; trigger = 1'b1;
        @(negedge clk);
        arm = 1'b0; trigger = held;
        wait_phase(P_WAIT, 60, "armed");
        chk("clear_pulses", clr_cnt, 1);
        chk("fill_writes", we_cnt, 17);
        if (!held) begin
            repeat (delay) @(negedge clk);
            trigger = 1'b1;
        end
        @(negedge clk);
        trigger = 1'b0;
        post_count = 4'($urandom);
        wait_phase(P_DONE, 400, "done");
        chk("final_trig_index", trig_index, etrig);
        chk("total_writes", we_cnt, ewe);
        chk("accepted_words", acc_cnt, 16);
        chk("address_cover", mask, 16'hffff);
        chk("duplicates", dup_cnt, 0);
        chk("last_count", last_cnt, 1);
        chk("done_held", done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mem[i]) mem[i] = 8'(i + 8'h30);
        reset = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0; post_count = '0;
        repeat (3) @(negedge clk);
        chk("rst_buf_clear", buf_clear, 0);
        chk("rst_write_enable", write_enable, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_trig_index", trig_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        check_en = 1'b1;

        run_capture(2, 3, 1'b0, 0, 13, 23);
        run_capture(5, 0, 1'b1, 0, 10, 23);
        run_capture(0, 0, 1'b1, 0, 15, 18);
        run_capture(7, 4, 1'b0, 1, 8, 29);
        run_capture(3, 0, 1'b1, 1, 12, 21);
        run_capture(15, 0, 1'b1, 0, 0, 33);

        // Abort during post-trigger recording.
        ready_mode = 0;
        start_arm(10, 1'b1);
        wait_phase(P_POST, 60, "post");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; trigger = 1'b0;
        chk("abort_write_enable", write_enable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_trig_index", trig_index, 0);
        chk("abort_raddr", raddr, 0);
        chk("abort_o_valid", o_valid, 0);

        // Reset in the middle of readout.
        start_arm(4, 1'b1);
        wait_phase(P_READ, 60, "readout");
        trigger = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_o_valid", o_valid, 0);
        chk("rstmid_o_data", o_data, 0);
        chk("rstmid_o_last", o_last, 0);
        chk("rstmid_raddr", raddr, 0);
        chk("rstmid_trig_index", trig_index, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);

        for (int k = 0; k < 6; k++) begin
            int pc, dl, rm;
            bit hd;
            pc = $urandom_range(0, 15);
            dl = $urandom_range(0, 6);
            hd = 1'($urandom_range(0, 1));
            rm = $urandom_range(0, 1);
            run_capture(pc, dl, hd, rm, 15 - pc, 18 + (hd ? 0 : dl) + pc);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
